// File: rtl/pipe_result_collector_pkg.sv
// Shared definitions for the pipeline result collector and the pipeline
// stage registers that feed it.
//   - RES_DEPTH_DEF / RES_WIDTH_DEF : default FIFO depth and sum width
//   - result_t                      : result record (sum + overflow flag)
//   - credit_ok()                   : launch-credit test shared by issuer logic
package pipe_result_collector_pkg;

  localparam int RES_DEPTH_DEF = 4;
  localparam int RES_WIDTH_DEF = 32;

  // Result record as carried by the final pipeline stage.
  typedef struct packed {
    logic [RES_WIDTH_DEF-1:0] sum;
    logic                     overflow;
  } result_t;

  // A new item may be launched only while stored plus in-flight results
  // leave at least one free FIFO slot for it.
  function automatic logic credit_ok(input int unsigned used,
                                     input int unsigned depth);
    return used < depth;
  endfunction

endpackage

// File: rtl/pipe_result_collector_result_fifo.sv
// result_fifo: result storage for the collector.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, wr_data  : write request; accepted when not full or when a read
//                     happens in the same cycle
//   rd_en           : remove head (ignored when empty)
//   rd_data         : head entry, forced to zero while empty
//   count           : number of stored entries (0..DEPTH)
//   full, empty     : count == DEPTH / count == 0
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A write into a full FIFO is only legal when the head leaves this cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Stale storage is hidden while empty so the outputs read zero after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pipe_result_collector.sv
// pipe_result_collector: collects final results from a recirculating
// pipeline into a small FIFO and hands out launch credits to the issuer.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid, in_sum,
//   in_overflow, in_flag_next : final-stage item; stored only when valid
//                               and not recirculating
//   in_issue / issue_ok       : issuer launch request / credit available
//   res_valid, res_ready,
//   res_sum, res_overflow     : FIFO head handshake towards downstream
//   occupancy                 : stored result count
//   err_drop                  : sticky, set on a lost result or refused issue
module pipe_result_collector
  import pipe_result_collector_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH_DEF,
  parameter int WIDTH = RES_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_sum,
  input  logic                   in_overflow,
  input  logic                   in_flag_next,
  input  logic                   in_issue,
  output logic                   issue_ok,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_overflow,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_drop
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          capture, pop, issue_acc;
  logic          fifo_full, fifo_empty;
  logic [WIDTH:0] head;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_drop_q, err_drop_d;

  assign capture = in_valid && !in_flag_next;
  assign pop     = res_valid && res_ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_result_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data ({in_overflow, in_sum}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_valid    = !fifo_empty;
  assign res_sum      = head[WIDTH-1:0];
  assign res_overflow = head[WIDTH];

  // Credit depends on registered state only, never on this cycle's inputs.
  assign issue_ok  = credit_ok(int'(occupancy) + int'(inflight_q), DEPTH);
  assign issue_acc = in_issue && issue_ok;

  always_comb begin
    inflight_d = inflight_q;
    // A capture with nothing in flight (untracked item) must not underflow.
    if (issue_acc && !capture)
      inflight_d = inflight_q + CW'(1);
    else if (!issue_acc && capture && (inflight_q != '0))
      inflight_d = inflight_q - CW'(1);

    err_drop_d = err_drop_q
               | (capture && fifo_full && !pop)
               | (in_issue && !issue_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_drop_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign err_drop = err_drop_q;

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector (DEPTH=4, WIDTH=32).
module tb_pipe_result_collector;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_sum;
  logic             in_overflow;
  logic             in_flag_next;
  logic             in_issue;
  logic             issue_ok;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_overflow;
  logic [2:0]       occupancy;
  logic             err_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .in_flag_next (in_flag_next),
    .in_issue     (in_issue),
    .issue_ok     (issue_ok),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sum      (res_sum),
    .res_overflow (res_overflow),
    .occupancy    (occupancy),
    .err_drop     (err_drop)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic o,
                       input logic nxt, input logic iss, input logic rdy);
    in_valid     = v;
    in_sum       = s;
    in_overflow  = o;
    in_flag_next = nxt;
    in_issue     = iss;
    res_ready    = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    step();
    step();

    // Reset state
    check("rst_occ",      64'(occupancy),    64'd0);
    check("rst_valid",    64'(res_valid),    64'd0);
    check("rst_sum",      64'(res_sum),      64'd0);
    check("rst_ovf",      64'(res_overflow), 64'd0);
    check("rst_err",      64'(err_drop),     64'd0);
    check("rst_issue_ok", 64'(issue_ok),     64'd1);
    rst = 1'b0;

    // Single capture, latency 1, then popped
    drive(1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    check("lat1_valid", 64'(res_valid), 64'd1);
    check("lat1_sum",   64'(res_sum),   64'h10);
    check("lat1_occ",   64'(occupancy), 64'd1);
    step();
    check("lat1_gone",  64'(res_valid), 64'd0);
    check("lat1_occ0",  64'(occupancy), 64'd0);

    // Fill with 1..4 while downstream stalls; item 2 carries overflow
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), (i == 2), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    check("full_occ",      64'(occupancy), 64'd4);
    check("full_issue_ok", 64'(issue_ok),  64'd0);
    check("full_head",     64'(res_sum),   64'd1);
    step();
    check("stall_hold",    64'(res_sum),   64'd1);
    check("stall_err",     64'(err_drop),  64'd0);

    // Capture into a full FIFO without a pop: dropped
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("drop_err",  64'(err_drop),  64'd1);
    check("drop_occ",  64'(occupancy), 64'd4);
    check("drop_head", 64'(res_sum),   64'd1);

    // Capture into a full FIFO with a pop: accepted, pointer wraps
    drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    check("swap_occ",  64'(occupancy),    64'd4);
    check("swap_err",  64'(err_drop),     64'd1);
    check("order_2",   64'(res_sum),      64'd2);
    check("order_2o",  64'(res_overflow), 64'd1);
    step();
    check("order_3",   64'(res_sum),      64'd3);
    check("order_3o",  64'(res_overflow), 64'd0);
    step();
    check("order_4",   64'(res_sum),      64'd4);
    step();
    check("order_5",   64'(res_sum),      64'd5);
    check("order_5o",  64'(res_overflow), 64'd1);
    step();
    check("drain_valid", 64'(res_valid), 64'd0);
    check("drain_occ",   64'(occupancy), 64'd0);

    // Fresh start for credit checks
    rst = 1'b1;
    idle(1'b0);
    step();
    rst = 1'b0;
    check("rst2_err", 64'(err_drop), 64'd0);

    // Issue one, then a recirculating item must leave credit untouched
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("iss1_ok", 64'(issue_ok), 64'd1);
    drive(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("recirc_occ",   64'(occupancy), 64'd0);
    check("recirc_valid", 64'(res_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check("iss3_ok", 64'(issue_ok), 64'd1);
    step();
    idle(1'b0);
    check("iss4_ok",  64'(issue_ok), 64'd0);
    check("iss4_err", 64'(err_drop), 64'd0);

    // Capture one (inflight 3, occ 1), then pop it: credit returns
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle(1'b1);
    check("cap_ok",  64'(issue_ok),  64'd0);
    check("cap_occ", 64'(occupancy), 64'd1);
    step();
    idle(1'b0);
    check("pop_ok",  64'(issue_ok),  64'd1);

    // Use the credit, then a refused issue sets err_drop
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("reiss_ok", 64'(issue_ok), 64'd0);
    step();
    idle(1'b0);
    check("refuse_err", 64'(err_drop), 64'd1);
    check("refuse_ok",  64'(issue_ok), 64'd0);

    // Three captures: occupancy 3, inflight 1
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(1'b0);
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    check("pre_rst_ok",  64'(issue_ok),  64'd0);

    // Mid-operation reset with active inputs that must be ignored
    rst = 1'b1;
    drive(1'b1, 32'h999, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    idle(1'b0);
    check("mrst_occ",   64'(occupancy), 64'd0);
    check("mrst_valid", 64'(res_valid), 64'd0);
    check("mrst_err",   64'(err_drop),  64'd0);
    check("mrst_ok",    64'(issue_ok),  64'd1);
    check("mrst_sum",   64'(res_sum),   64'd0);

    // Untracked capture with inflight 0 must not underflow the counter
    drive(1'b1, 32'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    check("untrk_sum", 64'(res_sum), 64'h42);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step();
    check("nounder_ok3", 64'(issue_ok), 64'd1);
    step();
    idle(1'b0);
    check("nounder_ok4", 64'(issue_ok), 64'd0);
    check("nounder_err", 64'(err_drop), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
